// File: rtl/dwpw_layer_seq.sv
// dwpw_layer_seq: sequencer for one depthwise 3x3 + pointwise 1x1 layer pair.
// Drives feature-map read/write addresses, per-channel start pulses and ping-pong selects.
module dwpw_layer_seq #(
    parameter int LAYER_DW_NUM = 1,
    parameter int LAYER_PW_NUM = 2,
    parameter int DW_IN_CH     = 16,
    parameter int DW_IN_HW     = 64,
    parameter int DW_STRIDE    = 1,
    parameter int PW_OUT_CH    = 32,
    parameter int CH_W         = 10,
    parameter int HW_W         = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mode,
    output logic            busy,
    output logic            done,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [CH_W-1:0] rd_ch,
    output logic [HW_W-1:0] rd_h,
    output logic [HW_W-1:0] rd_w,
    output logic            rd_last,
    output logic            rd_buf_sel,
    input  logic            res_valid,
    output logic            res_ready,
    output logic            wr_en,
    output logic [CH_W-1:0] wr_ch,
    output logic [HW_W-1:0] wr_h,
    output logic [HW_W-1:0] wr_w,
    output logic            wr_buf_sel,
    output logic            dw_start,
    output logic            pw_start,
    output logic [CH_W-1:0] dw_ch,
    output logic [CH_W-1:0] pw_oc,
    output logic            bs_start,
    output logic [4:0]      bs_layer,
    output logic [CH_W-1:0] bs_ch
);

    localparam int DW_OUT_HW = DW_IN_HW / DW_STRIDE;
    localparam logic [HW_W-1:0] IN_MAX  = HW_W'(DW_IN_HW - 1);
    localparam logic [HW_W-1:0] OUT_MAX = HW_W'(DW_OUT_HW - 1);
    localparam logic [CH_W-1:0] IC_MAX  = CH_W'(DW_IN_CH - 1);
    localparam logic [CH_W-1:0] OC_MAX  = CH_W'(PW_OUT_CH - 1);
    localparam logic [4:0] DW_LAYER = 5'(LAYER_DW_NUM);
    localparam logic [4:0] PW_LAYER = 5'(LAYER_PW_NUM);

    typedef enum logic [2:0] {
        IDLE,
        DW_CH,
        DW_RUN,
        PW_CH,
        PW_RUN,
        DONE
    } state_t;

    state_t state;
    logic dw_only;

    logic rd_fire;
    logic ic_wrap;
    logic rd_end;
    logic wr_end;
    logic rd_idle;
    logic wr_idle;
    logic [HW_W-1:0] rd_lim;

    assign wr_en   = res_valid & res_ready;
    assign rd_fire = rd_valid & rd_ready;
    // DW reads scan the full input; PW reads scan the DW output plane
    assign rd_lim  = rd_buf_sel ? OUT_MAX : IN_MAX;
    assign ic_wrap = !rd_buf_sel || (rd_ch == IC_MAX);
    assign rd_end  = rd_fire && ic_wrap && (rd_w == rd_lim) && (rd_h == rd_lim);
    assign wr_end  = wr_en && (wr_w == OUT_MAX) && (wr_h == OUT_MAX);
    assign rd_idle = !rd_valid || rd_end;
    assign wr_idle = !res_ready || wr_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            dw_only    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_ch      <= '0;
            rd_h       <= '0;
            rd_w       <= '0;
            rd_last    <= 1'b0;
            rd_buf_sel <= 1'b0;
            wr_buf_sel <= 1'b0;
            res_ready  <= 1'b0;
            wr_ch      <= '0;
            wr_h       <= '0;
            wr_w       <= '0;
            dw_start   <= 1'b0;
            pw_start   <= 1'b0;
            dw_ch      <= '0;
            pw_oc      <= '0;
            bs_start   <= 1'b0;
            bs_layer   <= '0;
            bs_ch      <= '0;
        end else begin
            dw_start <= 1'b0;
            pw_start <= 1'b0;
            bs_start <= 1'b0;
            done     <= 1'b0;

            if (rd_fire) begin
                if (rd_buf_sel && !ic_wrap) begin
                    rd_ch   <= rd_ch + 1'b1;
                    rd_last <= (rd_ch + 1'b1 == IC_MAX);
                end else begin
                    if (rd_buf_sel) begin
                        rd_ch   <= '0;
                        rd_last <= (IC_MAX == '0);
                    end
                    rd_w <= (rd_w == rd_lim) ? '0 : rd_w + 1'b1;
                    if (rd_w == rd_lim)
                        rd_h <= (rd_h == rd_lim) ? '0 : rd_h + 1'b1;
                end
                if (rd_end) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end
            end

            if (wr_en) begin
                wr_w <= (wr_w == OUT_MAX) ? '0 : wr_w + 1'b1;
                if (wr_w == OUT_MAX)
                    wr_h <= (wr_h == OUT_MAX) ? '0 : wr_h + 1'b1;
                if (wr_end)
                    res_ready <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        dw_only <= (mode == 2'b01);
                        if (mode == 2'b10) begin
                            state      <= PW_CH;
                            pw_oc      <= '0;
                            pw_start   <= 1'b1;
                            bs_start   <= 1'b1;
                            bs_layer   <= PW_LAYER;
                            bs_ch      <= '0;
                            rd_buf_sel <= 1'b1;
                            wr_buf_sel <= 1'b0;
                        end else begin
                            state      <= DW_CH;
                            dw_ch      <= '0;
                            dw_start   <= 1'b1;
                            bs_start   <= 1'b1;
                            bs_layer   <= DW_LAYER;
                            bs_ch      <= '0;
                            rd_buf_sel <= 1'b0;
                            wr_buf_sel <= 1'b1;
                        end
                    end
                end
                DW_CH: begin
                    state     <= DW_RUN;
                    rd_valid  <= 1'b1;
                    rd_ch     <= dw_ch;
                    rd_h      <= '0;
                    rd_w      <= '0;
                    rd_last   <= 1'b0;
                    res_ready <= 1'b1;
                    wr_ch     <= dw_ch;
                    wr_h      <= '0;
                    wr_w      <= '0;
                end
                DW_RUN: begin
                    if (rd_idle && wr_idle) begin
                        if (dw_ch != IC_MAX) begin
                            state    <= DW_CH;
                            dw_ch    <= dw_ch + 1'b1;
                            dw_start <= 1'b1;
                            bs_start <= 1'b1;
                            bs_layer <= DW_LAYER;
                            bs_ch    <= dw_ch + 1'b1;
                        end else begin
                            dw_ch <= '0;
                            if (dw_only) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state      <= PW_CH;
                                pw_oc      <= '0;
                                pw_start   <= 1'b1;
                                bs_start   <= 1'b1;
                                bs_layer   <= PW_LAYER;
                                bs_ch      <= '0;
                                rd_buf_sel <= 1'b1;
                                wr_buf_sel <= 1'b0;
                            end
                        end
                    end
                end
                PW_CH: begin
                    state     <= PW_RUN;
                    rd_valid  <= 1'b1;
                    rd_ch     <= '0;
                    rd_h      <= '0;
                    rd_w      <= '0;
                    rd_last   <= (IC_MAX == '0);
                    res_ready <= 1'b1;
                    wr_ch     <= pw_oc;
                    wr_h      <= '0;
                    wr_w      <= '0;
                end
                PW_RUN: begin
                    if (rd_idle && wr_idle) begin
                        if (pw_oc != OC_MAX) begin
                            state    <= PW_CH;
                            pw_oc    <= pw_oc + 1'b1;
                            pw_start <= 1'b1;
                            bs_start <= 1'b1;
                            bs_layer <= PW_LAYER;
                            bs_ch    <= pw_oc + 1'b1;
                        end else begin
                            pw_oc <= '0;
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dwpw_layer_seq.sv
// tb_dwpw_layer_seq: random-stimulus bench for dwpw_layer_seq at stride 1 and 2,
// scored against loop-nest reference streams of reads, writes and start pulses.
module tb_dwpw_layer_seq;

    localparam int CH  = 2;
    localparam int HW  = 4;
    localparam int OC  = 3;
    localparam int CW  = 10;
    localparam int HWW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] mode = 2'b00;
    logic start [2] = '{1'b0, 1'b0};
    logic rd_ready = 1'b1;
    logic res_gate = 1'b1;
    logic clr = 1'b0;
    bit rnd_rdy = 1'b0;
    bit rnd_res = 1'b0;

    logic busy [2], done [2], rd_valid [2], rd_last [2], rd_buf_sel [2];
    logic res_valid [2], res_ready [2], wr_en [2], wr_buf_sel [2];
    logic dw_start [2], pw_start [2], bs_start [2];
    logic [CW-1:0] rd_ch [2], wr_ch [2], dw_ch [2], pw_oc [2], bs_ch [2];
    logic [HWW-1:0] rd_h [2], rd_w [2], wr_h [2], wr_w [2];
    logic [4:0] bs_layer [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [2:0] echo;
        int pend;

        dwpw_layer_seq #(
            .LAYER_DW_NUM(1), .LAYER_PW_NUM(2), .DW_IN_CH(CH), .DW_IN_HW(HW),
            .DW_STRIDE(k + 1), .PW_OUT_CH(OC), .CH_W(CW), .HW_W(HWW)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start[k]), .mode(mode),
            .busy(busy[k]), .done(done[k]),
            .rd_valid(rd_valid[k]), .rd_ready(rd_ready),
            .rd_ch(rd_ch[k]), .rd_h(rd_h[k]), .rd_w(rd_w[k]),
            .rd_last(rd_last[k]), .rd_buf_sel(rd_buf_sel[k]),
            .res_valid(res_valid[k]), .res_ready(res_ready[k]),
            .wr_en(wr_en[k]), .wr_ch(wr_ch[k]), .wr_h(wr_h[k]), .wr_w(wr_w[k]),
            .wr_buf_sel(wr_buf_sel[k]),
            .dw_start(dw_start[k]), .pw_start(pw_start[k]),
            .dw_ch(dw_ch[k]), .pw_oc(pw_oc[k]),
            .bs_start(bs_start[k]), .bs_layer(bs_layer[k]), .bs_ch(bs_ch[k])
        );

        // result source: each DW read / each completed PW pixel returns 3 cycles later
        assign res_valid[k] = (pend != 0) && res_gate;

        always @(posedge clk) begin
            if (!rst || clr) begin
                echo <= '0;
                pend <= 0;
            end else begin
                echo <= {echo[1:0], rd_valid[k] & rd_ready & (rd_buf_sel[k] ? rd_last[k] : 1'b1)};
                pend <= pend + int'(echo[2]) - int'(wr_en[k]);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rd_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        res_gate = rnd_res ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(int k);
        return {4'b0, rd_buf_sel[k], rd_last[k], rd_ch[k], rd_h[k], rd_w[k]};
    endfunction

    function automatic logic outs(int k);
        return |{busy[k], done[k], rd_valid[k], rd_last[k], rd_buf_sel[k],
                 res_ready[k], wr_en[k], wr_buf_sel[k], dw_start[k], pw_start[k],
                 bs_start[k], rd_ch[k], wr_ch[k], dw_ch[k], pw_oc[k], bs_ch[k],
                 rd_h[k], rd_w[k], wr_h[k], wr_w[k], bs_layer[k]};
    endfunction

    logic [31:0] act_rd[$], act_wr[$], act_st[$];
    logic [31:0] exp_rd[$], exp_wr[$], exp_st[$];
    int sel = 0;
    bit mon = 1'b0;
    int n_done, e_stall, e_sel, e_wren, e_bs, e_busy;
    bit prev_stall;
    logic [31:0] prev_rd;

    always @(negedge clk) begin
        int k;
        k = sel;
        if (mon && rst) begin
            if (prev_stall && (!rd_valid[k] || rd_word(k) != prev_rd))
                e_stall++;
            prev_stall = rd_valid[k] && !rd_ready;
            prev_rd = rd_word(k);
            if (rd_valid[k] && rd_ready)
                act_rd.push_back(rd_word(k));
            if (wr_en[k] != (res_valid[k] && res_ready[k]))
                e_wren++;
            if (wr_en[k])
                act_wr.push_back({5'b0, wr_buf_sel[k], wr_ch[k], wr_h[k], wr_w[k]});
            if (busy[k] && wr_buf_sel[k] == rd_buf_sel[k])
                e_sel++;
            if (bs_start[k] != (dw_start[k] | pw_start[k]))
                e_bs++;
            if (dw_start[k])
                act_st.push_back({5'b0, 2'd1, bs_layer[k], bs_ch[k], dw_ch[k]});
            if (pw_start[k])
                act_st.push_back({5'b0, 2'd2, bs_layer[k], bs_ch[k], pw_oc[k]});
            if (done[k])
                n_done++;
        end
    end

    // reference: the layer's address streams as plain loop nests
    task automatic build(input int s, input logic [1:0] m);
        int ohw;
        ohw = HW / (s + 1);
        exp_rd.delete();
        exp_wr.delete();
        exp_st.delete();
        if (m != 2'b10) begin
            for (int c = 0; c < CH; c++) begin
                exp_st.push_back({5'b0, 2'd1, 5'd1, CW'(c), CW'(c)});
                for (int h = 0; h < HW; h++)
                    for (int w = 0; w < HW; w++)
                        exp_rd.push_back({4'b0, 1'b0, 1'b0, CW'(c), HWW'(h), HWW'(w)});
                for (int h = 0; h < ohw; h++)
                    for (int w = 0; w < ohw; w++)
                        exp_wr.push_back({5'b0, 1'b1, CW'(c), HWW'(h), HWW'(w)});
            end
        end
        if (m != 2'b01) begin
            for (int oc = 0; oc < OC; oc++) begin
                exp_st.push_back({5'b0, 2'd2, 5'd2, CW'(oc), CW'(oc)});
                for (int h = 0; h < ohw; h++)
                    for (int w = 0; w < ohw; w++) begin
                        for (int ic = 0; ic < CH; ic++)
                            exp_rd.push_back({4'b0, 1'b1, ic == CH - 1, CW'(ic), HWW'(h), HWW'(w)});
                        exp_wr.push_back({5'b0, 1'b0, CW'(oc), HWW'(h), HWW'(w)});
                    end
            end
        end
    endtask

    task automatic cmp_q(input string tag, input logic [31:0] a[$], input logic [31:0] e[$]);
        int idx;
        check({tag, "_count"}, a.size(), e.size());
        if (a.size() == 0 || e.size() == 0)
            return;
        idx = (a.size() < e.size() ? a.size() : e.size()) - 1;
        for (int i = 0; i < idx; i++)
            if (a[i] !== e[i]) begin
                idx = i;
                break;
            end
        check(tag, a[idx], e[idx]);
    endtask

    task automatic run(input string nm, input int s, input logic [1:0] m,
                       input bit rr, input bit rv, input bit spam);
        int cyc;
        build(s, m);
        act_rd.delete();
        act_wr.delete();
        act_st.delete();
        n_done = 0; e_stall = 0; e_sel = 0; e_wren = 0; e_bs = 0; e_busy = 0;
        prev_stall = 1'b0;
        sel = s;
        mode = m;
        rnd_rdy = rr;
        rnd_res = rv;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        mon = 1'b1;
        start[s] = 1'b1;
        @(posedge clk); #1;
        start[s] = 1'b0;
        cyc = 0;
        while (!done[s] && cyc < 4000) begin
            if (!busy[s])
                e_busy++;
            if (spam)
                start[s] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        start[s] = 1'b0;
        check({nm, "_timeout"}, cyc < 4000, 1);
        repeat (6) @(posedge clk);
        #1;
        mon = 1'b0;
        rnd_rdy = 1'b0;
        rnd_res = 1'b0;
        check({nm, "_done_cnt"}, n_done, 1);
        check({nm, "_idle_after"}, busy[s], 0);
        check({nm, "_busy_gap"}, e_busy, 0);
        check({nm, "_rd_stable"}, e_stall, 0);
        check({nm, "_buf_sel"}, e_sel, 0);
        check({nm, "_wr_en"}, e_wren, 0);
        check({nm, "_bs_start"}, e_bs, 0);
        cmp_q({nm, "_rd"}, act_rd, exp_rd);
        cmp_q({nm, "_wr"}, act_wr, exp_wr);
        cmp_q({nm, "_st"}, act_st, exp_st);
    endtask

    initial begin
        int cyc;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_s1", outs(0), 0);
        check("reset_s2", outs(1), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run("t1_base", 0, 2'b00, 0, 0, 0);
        run("t2_stride2", 1, 2'b00, 0, 0, 0);
        run("t3_rand_rdy", 0, 2'b00, 1, 1, 0);
        run("t4_start_spam", 0, 2'b00, 1, 0, 1);

        // reset pulse in the middle of the PW pass
        sel = 0;
        mode = 2'b00;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        cyc = 0;
        while (!(rd_buf_sel[0] && rd_valid[0]) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t5_reach_pw", cyc < 2000, 1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t5_mid_busy", busy[0], 0);
        check("t5_mid_zero", outs(0), 0);
        rst = 1'b1;
        run("t5_after_rst", 0, 2'b00, 0, 0, 0);

        run("t6_dw_only", 0, 2'b01, 0, 0, 0);
        run("t6_pw_only", 0, 2'b10, 0, 0, 0);
        run("t7_mode11_s2", 1, 2'b11, 1, 1, 0);
        run("t7_pw_only_s2", 1, 2'b10, 1, 1, 1);

        // start coinciding with the reset edge must be dropped
        @(posedge clk); #1;
        rst = 1'b0;
        start[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        check("start_at_rst", busy[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
